// File: rtl/spike_pkg.sv
// Shared types and constants for the spike event packetizer: record layout,
// header byte bit positions and the byte-serialiser state encoding.
package spike_pkg;

    localparam int UNIT_W = 3;
    localparam int CODE_W = 2;
    localparam int TS_W   = 16;
    localparam int REC_W  = UNIT_W + CODE_W + TS_W;

    localparam int HDR_SYNC_BIT = 7;
    localparam int HDR_UNIT_HI  = 6;
    localparam int HDR_UNIT_LO  = 4;
    localparam int HDR_CODE_HI  = 3;
    localparam int HDR_CODE_LO  = 2;
    localparam int HDR_DROP_BIT = 1;

    localparam logic HDR_SYNC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_TS_HI = 2'd2,
        ST_TS_LO = 2'd3
    } byte_state_t;

    typedef struct packed {
        logic [UNIT_W-1:0] unit;
        logic [CODE_W-1:0] code;
        logic [TS_W-1:0]   ts;
    } record_t;

    // Header byte; the drop bit is supplied separately because it is sampled at pop time.
    function automatic logic [7:0] make_header(input record_t rec, input logic drop);
        logic [7:0] hdr;
        hdr                           = '0;
        hdr[HDR_SYNC_BIT]             = HDR_SYNC;
        hdr[HDR_UNIT_HI:HDR_UNIT_LO]  = rec.unit;
        hdr[HDR_CODE_HI:HDR_CODE_LO]  = rec.code;
        hdr[HDR_DROP_BIT]             = drop;
        return hdr;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Record FIFO with show-ahead head read, so a pop and its data land in the same cycle.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module event_fifo
    import spike_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [REC_W-1:0]         push_data,
    input  logic                     pop,
    output logic [REC_W-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/spike_event_packetizer.sv
// Turns per-unit spike rising edges into timestamped 3-byte records and streams
// them out over a valid/ready byte port, flagging records lost to coalescing.
module spike_event_packetizer
    import spike_pkg::*;
#(
    parameter int NUM_UNITS  = 2,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic [NUM_UNITS-1:0]          spike_in,
    input  logic [2*NUM_UNITS-1:0]        event_in,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          drop_flag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int LATCH_W = CODE_W + TS_WIDTH;

    logic [TS_WIDTH-1:0]  ts_reg;
    logic [NUM_UNITS-1:0] spike_prev_reg;
    logic [NUM_UNITS-1:0] pending_reg;
    logic [LATCH_W-1:0]   latch_reg [NUM_UNITS];

    logic [NUM_UNITS-1:0] rise;
    logic [NUM_UNITS-1:0] coalesce;
    logic [NUM_UNITS-1:0] push_clear;

    logic                 sel_valid;
    logic [UNIT_W-1:0]    sel_idx;
    logic [LATCH_W-1:0]   sel_latch;
    logic                 push;
    record_t              push_rec;

    record_t              head_rec;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    byte_state_t          state_reg;
    logic [7:0]           out_byte_reg;
    logic                 out_valid_reg;
    logic                 drop_flag_reg;
    logic [TS_W-1:0]      rec_ts_reg;
    logic                 drop_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg         <= '0;
            spike_prev_reg <= '0;
        end else begin
            if (sample_tick) begin
                ts_reg <= ts_reg + 1'b1;
            end
            spike_prev_reg <= spike_in;
        end
    end

    // A unit being pushed this cycle frees its latch, so a new edge there loses nothing.
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
        assign rise[gi]       = spike_in[gi] & ~spike_prev_reg[gi];
        assign push_clear[gi] = push && (sel_idx == UNIT_W'(gi));
        assign coalesce[gi]   = rise[gi] & pending_reg[gi] & ~push_clear[gi];
    end

    assign drop_event = |coalesce;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                latch_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (rise[i]) begin
                    pending_reg[i] <= 1'b1;
                    latch_reg[i]   <= {event_in[2*i +: CODE_W], ts_reg};
                end else if (push_clear[i]) begin
                    pending_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Lowest-index pending unit wins the single push slot.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_latch = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                sel_valid = 1'b1;
                sel_idx   = UNIT_W'(i);
                sel_latch = latch_reg[i];
            end
        end
    end

    assign push     = sel_valid && (!fifo_full || fifo_pop);
    assign push_rec = {sel_idx, sel_latch};

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_rec),
        .pop       (fifo_pop),
        .pop_data  (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_pop = !fifo_empty &&
                      ((state_reg == ST_IDLE) ||
                       (state_reg == ST_TS_LO && out_valid_reg && out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_byte_reg  <= '0;
            out_valid_reg <= 1'b0;
            drop_flag_reg <= 1'b0;
            rec_ts_reg    <= '0;
        end else begin
            // A drop in the same cycle as a pop keeps the flag set.
            if (drop_event) begin
                drop_flag_reg <= 1'b1;
            end else if (fifo_pop) begin
                drop_flag_reg <= 1'b0;
            end

            if (fifo_pop) begin
                rec_ts_reg    <= head_rec.ts;
                out_byte_reg  <= make_header(head_rec, drop_flag_reg);
                out_valid_reg <= 1'b1;
                state_reg     <= ST_HDR;
            end else begin
                case (state_reg)
                    ST_HDR: begin
                        if (out_ready) begin
                            out_byte_reg <= rec_ts_reg[15:8];
                            state_reg    <= ST_TS_HI;
                        end
                    end
                    ST_TS_HI: begin
                        if (out_ready) begin
                            out_byte_reg <= rec_ts_reg[7:0];
                            state_reg    <= ST_TS_LO;
                        end
                    end
                    ST_TS_LO: begin
                        if (out_ready) begin
                            out_byte_reg  <= '0;
                            out_valid_reg <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end
                    end
                    default: begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_byte  = out_byte_reg;
    assign out_valid = out_valid_reg;
    assign drop_flag = drop_flag_reg;

endmodule
